// File: rtl/prog_counter_if.sv
// prog_counter_if -- control/data bundle for one prog_counter stage.
//
// Members (names follow the counter's pin list):
//   sclr_n    : synchronous active-low clear
//   load_n    : synchronous active-low parallel load
//   d         : load / reload data, WIDTH bits
//   up        : count direction, 1 = up, 0 = down
//   p, t      : parallel and trickle count enables
//   wrap_load : 1 = reload d at terminal (divide-by-N mode)
//   ca        : combinational terminal-count carry/borrow (t AND terminal)
//   q         : counter value, WIDTH bits
//   tc_q      : registered one-cycle terminal-event pulse
//
// master drives the controls and observes the counter; slave is the counter.
interface prog_counter_if #(
  parameter int WIDTH = 4
);
  logic             sclr_n;
  logic             load_n;
  logic [WIDTH-1:0] d;
  logic             up;
  logic             p;
  logic             t;
  logic             wrap_load;
  logic             ca;
  logic [WIDTH-1:0] q;
  logic             tc_q;

  modport master (
    output sclr_n, load_n, d, up, p, t, wrap_load,
    input  ca, q, tc_q
  );

  modport slave (
    input  sclr_n, load_n, d, up, p, t, wrap_load,
    output ca, q, tc_q
  );
endinterface

// File: rtl/prog_counter.sv
// prog_counter -- presettable up/down binary counter with 74x161-style
// P/T enables, cascadable carry and an optional divide-by-N reload.
//
// Ports:
//   clk     : rising-edge clock, the only clock
//   clear_n : asynchronous active-low reset (q <= RESET_VAL, tc_q <= 0)
//   bus     : prog_counter_if.slave carrying sclr_n, load_n, d, up, p, t,
//             wrap_load (inputs) and ca, q, tc_q (outputs)
//
// Parameters:
//   WIDTH     : counter width, 2..32
//   RESET_VAL : value of q after any clear, truncated to WIDTH bits
//
// Edge priority with clear_n high: sclr_n low > load_n low > count > hold.
// A count step needs both p and t. ca = t & terminal is purely combinational
// so a following stage can use it directly as its t input.
module prog_counter #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic           clk,
  input  logic           clear_n,
  prog_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] RST_Q    = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             tc_reg;
  logic             tc_next;
  logic             terminal;
  logic             step;

  // Terminal depends on the live direction input, so flipping up is seen
  // by ca and by the very next edge without an extra step.
  assign terminal = bus.up ? (q_reg == ALL_ONES) : (q_reg == ZERO);
  assign step     = bus.p & bus.t;

  assign bus.ca   = bus.t & terminal;
  assign bus.q    = q_reg;
  assign bus.tc_q = tc_reg;

  always_comb begin
    q_next  = q_reg;
    tc_next = 1'b0;
    if (!bus.sclr_n) begin
      q_next = RST_Q;
    end else if (!bus.load_n) begin
      // A load never reports a terminal event, even when d lands on it.
      q_next = bus.d;
    end else if (step) begin
      tc_next = terminal;
      if (terminal && bus.wrap_load) begin
        q_next = bus.d;
      end else if (bus.up) begin
        // At all-ones this naturally wraps to zero.
        q_next = q_reg + ONE;
      end else begin
        // At zero this naturally wraps to all-ones.
        q_next = q_reg - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q_reg  <= RST_Q;
      tc_reg <= 1'b0;
    end else begin
      q_reg  <= q_next;
      tc_reg <= tc_next;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
module tb_prog_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_a, clr_c, clr_w, clr_r;

  prog_counter_if #(.WIDTH(4))  bus_a ();
  prog_counter_if #(.WIDTH(4))  bus_lo ();
  prog_counter_if #(.WIDTH(4))  bus_hi ();
  prog_counter_if #(.WIDTH(32)) bus_w ();
  prog_counter_if #(.WIDTH(5))  bus_r ();

  prog_counter #(.WIDTH(4),  .RESET_VAL(0))  dut_a  (.clk(clk), .clear_n(clr_a), .bus(bus_a));
  prog_counter #(.WIDTH(4),  .RESET_VAL(0))  dut_lo (.clk(clk), .clear_n(clr_c), .bus(bus_lo));
  prog_counter #(.WIDTH(4),  .RESET_VAL(0))  dut_hi (.clk(clk), .clear_n(clr_c), .bus(bus_hi));
  prog_counter #(.WIDTH(32), .RESET_VAL(0))  dut_w  (.clk(clk), .clear_n(clr_w), .bus(bus_w));
  prog_counter #(.WIDTH(5),  .RESET_VAL(37)) dut_r  (.clk(clk), .clear_n(clr_r), .bus(bus_r));

  // Cascade: upper stage trickle enable comes from the lower stage carry.
  assign bus_hi.t = bus_lo.ca;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       sclr_n;
    logic       load_n;
    logic [3:0] d;
    logic       up;
    logic       p;
    logic       t;
    logic       wl;
    logic [3:0] eq;
    logic       etc;
    logic       eca;
  } vec_t;

  vec_t vecs[14];

  // Random reference model for the WIDTH=5, RESET_VAL=37 (-> 5) instance.
  localparam int RM  = 32;
  localparam int RRV = 37 % 32;

  initial begin
    int   qm, tcm;
    int   exp_v;
    logic term;
    logic [7:0] cnt8;

    // Table: inputs applied for one edge, expected q/tc_q after it and ca
    // with the same inputs against the new q. Starts from q = 0.
    vecs[0]  = '{1'b0, 1'b0, 4'd9,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0}; // sclr beats load
    vecs[1]  = '{1'b1, 1'b0, 4'd9,  1'b1, 1'b0, 1'b1, 1'b0, 4'd9,  1'b0, 1'b0}; // load with p=0
    vecs[2]  = '{1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1}; // load all-ones: ca, no tc
    vecs[3]  = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0}; // wrap up
    vecs[4]  = '{1'b1, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0}; // wrap down
    vecs[5]  = '{1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 1'b0}; // hold p=0
    vecs[6]  = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0}; // hold t=0, ca gated
    vecs[7]  = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1}; // ca ignores p
    vecs[8]  = '{1'b1, 1'b0, 4'd3,  1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0}; // load 3
    vecs[9]  = '{1'b1, 1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 1'b1, 4'd7,  1'b1, 1'b0}; // reload at terminal
    vecs[13] = '{1'b0, 1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 1'b1}; // sclr clears tc

    clr_a = 1'b0; clr_c = 1'b0; clr_w = 1'b0; clr_r = 1'b0;
    bus_a.sclr_n = 1'b1; bus_a.load_n = 1'b1; bus_a.d = '0; bus_a.up = 1'b1;
    bus_a.p = 1'b0; bus_a.t = 1'b0; bus_a.wrap_load = 1'b0;
    bus_lo.sclr_n = 1'b1; bus_lo.load_n = 1'b1; bus_lo.d = '0; bus_lo.up = 1'b1;
    bus_lo.p = 1'b1; bus_lo.t = 1'b1; bus_lo.wrap_load = 1'b0;
    bus_hi.sclr_n = 1'b1; bus_hi.load_n = 1'b1; bus_hi.d = '0; bus_hi.up = 1'b1;
    bus_hi.p = 1'b1; bus_hi.wrap_load = 1'b0;
    bus_w.sclr_n = 1'b1; bus_w.load_n = 1'b1; bus_w.d = '0; bus_w.up = 1'b0;
    bus_w.p = 1'b0; bus_w.t = 1'b0; bus_w.wrap_load = 1'b0;
    bus_r.sclr_n = 1'b1; bus_r.load_n = 1'b1; bus_r.d = '0; bus_r.up = 1'b1;
    bus_r.p = 1'b0; bus_r.t = 1'b0; bus_r.wrap_load = 1'b0;

    tick(); tick();
    chk("reset_a_q",  bus_a.q,    32'd0);
    chk("reset_a_tc", bus_a.tc_q, 32'd0);
    chk("reset_r_q",  bus_r.q,    RRV);
    @(negedge clk);
    clr_a = 1'b1; clr_r = 1'b1; clr_w = 1'b1;
    tick();

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 14; i++) begin
      bus_a.sclr_n = vecs[i].sclr_n; bus_a.load_n = vecs[i].load_n;
      bus_a.d = vecs[i].d; bus_a.up = vecs[i].up; bus_a.p = vecs[i].p;
      bus_a.t = vecs[i].t; bus_a.wrap_load = vecs[i].wl;
      tick();
      $display("vec %0d: q=%0d tc_q=%0b ca=%0b", i, bus_a.q, bus_a.tc_q, bus_a.ca);
      chk($sformatf("vec%0d_q", i),  bus_a.q,    vecs[i].eq);
      chk($sformatf("vec%0d_tc", i), bus_a.tc_q, vecs[i].etc);
      chk($sformatf("vec%0d_ca", i), bus_a.ca,   vecs[i].eca);
    end

    // ---------------- free-running mod-16 up count from reset ----------------
    clr_a = 1'b0; #1; clr_a = 1'b1;
    bus_a.sclr_n = 1'b1; bus_a.load_n = 1'b1; bus_a.up = 1'b1;
    bus_a.p = 1'b1; bus_a.t = 1'b1; bus_a.wrap_load = 1'b0;
    #1;
    chk("cnt16_start", bus_a.q, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      $display("cnt16 step %0d: q=%0d tc_q=%0b ca=%0b", i, bus_a.q, bus_a.tc_q, bus_a.ca);
      chk("cnt16_q",  bus_a.q,    i % 16);
      chk("cnt16_tc", bus_a.tc_q, (i == 16) ? 1 : 0);
      chk("cnt16_ca", bus_a.ca,   (i % 16 == 15) ? 1 : 0);
    end

    // ---------------- divide-by-N, up then down ----------------
    bus_a.load_n = 1'b0; bus_a.d = 4'd12; tick();
    chk("divup_load", bus_a.q, 32'd12);
    bus_a.load_n = 1'b1; bus_a.wrap_load = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = 12 + (k % 4);
      $display("divup step %0d: q=%0d tc_q=%0b", k, bus_a.q, bus_a.tc_q);
      chk("divup_q",  bus_a.q,    exp_v);
      chk("divup_tc", bus_a.tc_q, (exp_v == 12) ? 1 : 0);
    end
    bus_a.load_n = 1'b0; bus_a.d = 4'd0; tick();
    chk("divdn_load", bus_a.q, 32'd0);
    bus_a.load_n = 1'b1; bus_a.up = 1'b0; bus_a.d = 4'd2;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_v = 2 - (k % 3);
      $display("divdn step %0d: q=%0d tc_q=%0b", k, bus_a.q, bus_a.tc_q);
      chk("divdn_q",  bus_a.q,    exp_v);
      chk("divdn_tc", bus_a.tc_q, (exp_v == 2) ? 1 : 0);
    end

    // ---------------- asynchronous clear mid-cycle ----------------
    bus_a.up = 1'b1; bus_a.wrap_load = 1'b0; bus_a.load_n = 1'b0; bus_a.d = 4'd7;
    tick();
    bus_a.load_n = 1'b1;
    chk("aclr_pre_q", bus_a.q, 32'd7);
    #3;
    clr_a = 1'b0;
    #1;
    chk("aclr_imm_q",  bus_a.q,    32'd0);
    chk("aclr_imm_tc", bus_a.tc_q, 32'd0);
    tick();
    chk("aclr_edge_ignored", bus_a.q, 32'd0);
    bus_a.p = 1'b0;
    #3;
    clr_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("aclr hold %0d: q=%0d tc_q=%0b", k, bus_a.q, bus_a.tc_q);
      chk("aclr_hold_q",  bus_a.q,    32'd0);
      chk("aclr_hold_tc", bus_a.tc_q, 32'd0);
    end
    bus_a.p = 1'b1;
    tick();
    chk("aclr_resume1", bus_a.q, 32'd1);
    chk("aclr_resume_tc", bus_a.tc_q, 32'd0);
    tick();
    chk("aclr_resume2", bus_a.q, 32'd2);

    // ---------------- two-stage cascade ----------------
    clr_c = 1'b1;
    bus_lo.load_n = 1'b0; bus_hi.load_n = 1'b0; bus_lo.d = 4'hE; bus_hi.d = 4'h0;
    tick();
    bus_lo.load_n = 1'b1; bus_hi.load_n = 1'b1;
    tick();
    cnt8 = {bus_hi.q, bus_lo.q};
    $display("cascade: %02h", cnt8);
    chk("casc_0f", cnt8, 32'h0F);
    tick();
    cnt8 = {bus_hi.q, bus_lo.q};
    $display("cascade: %02h hi_tc=%0b", cnt8, bus_hi.tc_q);
    chk("casc_10", cnt8, 32'h10);
    chk("casc_10_hitc", bus_hi.tc_q, 32'd0);
    chk("casc_10_lotc", bus_lo.tc_q, 32'd1);
    bus_lo.load_n = 1'b0; bus_hi.load_n = 1'b0; bus_lo.d = 4'hE; bus_hi.d = 4'hF;
    tick();
    bus_lo.load_n = 1'b1; bus_hi.load_n = 1'b1;
    tick();
    cnt8 = {bus_hi.q, bus_lo.q};
    chk("casc_ff", cnt8, 32'hFF);
    tick();
    cnt8 = {bus_hi.q, bus_lo.q};
    $display("cascade: %02h hi_tc=%0b", cnt8, bus_hi.tc_q);
    chk("casc_00", cnt8, 32'h00);
    chk("casc_00_hitc", bus_hi.tc_q, 32'd1);

    // ---------------- 32-bit down wrap ----------------
    bus_w.up = 1'b0; bus_w.p = 1'b1; bus_w.t = 1'b1;
    #1;
    chk("w32_ca_pre", bus_w.ca, 32'd1);
    tick();
    $display("w32: q=%08h tc_q=%0b", bus_w.q, bus_w.tc_q);
    chk("w32_q",  bus_w.q,    32'hFFFF_FFFF);
    chk("w32_tc", bus_w.tc_q, 32'd1);
    chk("w32_ca", bus_w.ca,   32'd0);
    tick();
    chk("w32_q2", bus_w.q, 32'hFFFF_FFFE);

    // ---------------- randomized vs reference model ----------------
    qm = RRV; tcm = 0;
    for (int it = 0; it < 400; it++) begin
      clr_r           = ($urandom_range(0, 99) < 3)  ? 1'b0 : 1'b1;
      bus_r.sclr_n    = ($urandom_range(0, 99) < 5)  ? 1'b0 : 1'b1;
      bus_r.load_n    = ($urandom_range(0, 99) < 10) ? 1'b0 : 1'b1;
      bus_r.p         = ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0;
      bus_r.t         = ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0;
      bus_r.up        = 1'($urandom_range(0, 1));
      bus_r.wrap_load = 1'($urandom_range(0, 1));
      bus_r.d         = 5'($urandom_range(0, RM - 1));
      if (!clr_r) begin
        qm = RRV; tcm = 0;
      end
      #1;
      term = bus_r.up ? (qm == RM - 1) : (qm == 0);
      chk("rnd_ca", bus_r.ca, (bus_r.t && term) ? 1 : 0);
      if (!clr_r) chk("rnd_aclr_q", bus_r.q, qm);
      tick();
      if (clr_r) begin
        if (!bus_r.sclr_n) begin
          qm = RRV; tcm = 0;
        end else if (!bus_r.load_n) begin
          qm = int'(bus_r.d); tcm = 0;
        end else if (bus_r.p && bus_r.t) begin
          tcm = term ? 1 : 0;
          if (term && bus_r.wrap_load) qm = int'(bus_r.d);
          else qm = (qm + (bus_r.up ? 1 : RM - 1)) % RM;
        end else begin
          tcm = 0;
        end
      end
      $display("rnd %0d: clr_n=%0b q=%0d tc_q=%0b model q=%0d tc=%0d",
               it, clr_r, bus_r.q, bus_r.tc_q, qm, tcm);
      chk("rnd_q",  bus_r.q,    qm);
      chk("rnd_tc", bus_r.tc_q, tcm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameters SHALL be:
  - WIDTH, default 4: counter width in bits, legal range 2..32.
  - RESET_VAL, default 0: value of q after clear, truncated to WIDTH bits.
REQ-002 Ports SHALL be:
  - clk  in  1: rising-edge clock, the only clock.
  - clear_n  in  1: asynchronous active-low reset.
  - sclr_n  in  1: synchronous active-low clear.
  - load_n  in  1: synchronous active-low parallel load.
  - d  in  WIDTH: load / reload data.
  - up  in  1: count direction, 1 = up, 0 = down.
  - p  in  1: count enable, parallel.
  - t  in  1: count enable, trickle; also gates ca.
  - wrap_load  in  1: 1 = reload d at terminal instead of wrapping (divide-by-N mode).
  - ca  out  1: combinational terminal-count carry/borrow.
  - q  out  WIDTH: counter value.
  - tc_q  out  1: registered one-cycle terminal-event pulse.
REQ-003 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-low on clear_n.

Function
REQ-004 Per rising clk edge with clear_n=1, priority SHALL be sclr_n low > load_n low > count > hold.
REQ-005 sclr_n=0 SHALL set q to RESET_VAL and tc_q to 0 at the next edge, regardless of load_n, p and t.
REQ-006 With sclr_n=1 and load_n=0, q SHALL take d at the next edge and tc_q SHALL be 0; p and t are ignored.
REQ-007 Count step SHALL occur iff sclr_n=1, load_n=1, p=1 and t=1.
REQ-008 terminal SHALL be defined as:
  - (up=1 and q = 2^WIDTH-1), or
  - (up=0 and q = 0).
REQ-009 On a count step with terminal=0, q SHALL become q+1 when up=1 and q-1 when up=0.
REQ-010 On a count step with terminal=1 and wrap_load=0, q SHALL wrap modulo 2^WIDTH:
  - up=1: all-ones -> 0.
  - up=0: 0 -> all-ones.
REQ-011 On a count step with terminal=1 and wrap_load=1, q SHALL take d, giving a period of (2^WIDTH - d) counts for up=1 and (d + 1) counts for up=0.
REQ-012 ca SHALL equal t AND terminal, combinationally from the current q, up and t, independent of p, load_n and sclr_n, so that stages cascade by driving the next stage's t from ca.
REQ-013 tc_q SHALL be 1 for exactly the one cycle after an edge on which a count step occurred with terminal=1, and 0 otherwise; consecutive terminal steps SHALL produce consecutive pulses.
REQ-014 When no count step occurs (p=0 or t=0, with load_n=1 and sclr_n=1), q SHALL hold and tc_q SHALL be 0 at the next edge.
REQ-015 A change of up SHALL take effect on the same edge it is sampled: terminal and ca re-evaluate immediately, and no extra step occurs.
REQ-016 Load SHALL bypass the terminal check: loading d equal to all-ones with up=1 SHALL make ca = t immediately, but SHALL NOT assert tc_q.
REQ-017 For WIDTH=4 and RESET_VAL=0, behaviour SHALL match a 74x161 when up=1, wrap_load=0 and sclr_n=1.

Reset
REQ-018 clear_n=0 SHALL immediately, without waiting for clk, force q to RESET_VAL and tc_q to 0; ca SHALL follow combinationally.
REQ-019 While clear_n=0, all clock edges SHALL be ignored.
REQ-020 Release of clear_n mid-sequence SHALL resume normal operation at the first clk edge after release, with no spurious tc_q pulse.

Verification
REQ-021 WIDTH=4, up=1, p=t=1, wrap_load=0 from reset -> q steps 0,1,...,15,0; ca=1 only while q=15; tc_q=1 in the cycle q=0 after the wrap.
REQ-022 WIDTH=4, up=1, wrap_load=1, d=12 -> q repeats 12,13,14,15,12 with period 4; tc_q pulses once per period; then flip up=0 with d=2 at q=0 -> sequence 2,1,0,2 with period 3.
REQ-023 Simultaneous sclr_n=0, load_n=0, d=9, p=t=1 -> q=RESET_VAL and tc_q=0; with sclr_n=1, load_n=0 and p=0 -> q=9 next cycle.
REQ-024 Two WIDTH=4 instances cascaded (stage-2 t = stage-1 ca, shared p=1) -> 8-bit count increments 0x0F -> 0x10 and 0xFF -> 0x00 correctly; stage-2 tc_q pulses only at 0xFF -> 0x00.
REQ-025 Assert clear_n=0 between clock edges at q=7 -> q=RESET_VAL immediately; release it, hold p=0 for 3 cycles -> q holds with tc_q=0; set p=1 -> counting resumes from RESET_VAL.
REQ-026 WIDTH=32, up=0 from q=0 with p=t=1 -> q=0xFFFFFFFF next cycle, ca=1 before the edge, tc_q=1 after it.
